// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states and WIDTH-independent constants.
package mult_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // op[0] selects divide, op[1] selects the unsigned variant
    localparam int OP_DIV_BIT = 0;
    localparam int OP_UNS_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of quotient, remainder and product.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    // negate when requested, pass through otherwise
    always_comb begin
        res_o = neg_i ? ((~val_i) + {{(WIDTH-1){1'b0}}, 1'b1}) : val_i;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit feeding the CPU HI/LO registers.
// One shared 2*WIDTH working register does shift-add multiply or restoring
// shift-subtract divide on operand magnitudes; signs are restored in FIX.
// Optional macro MULT_DIV_UNSIGNED_EN enables MULTU/DIVU (op[1]=1); without
// it op[1] is ignored and every op is treated as signed.
//
// state | meaning
// IDLE  | waiting for start; rejects divide-by-zero here
// RUN   | one multiply/divide iteration per clock, WIDTH iterations
// FIX   | sign correction, HI/LO write, done pulse
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;   // quotient / product negative
    logic               neg_hi_q, neg_hi_d;   // remainder negative
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;       // multiplier or divisor magnitude
    logic [2*WIDTH-1:0] work_q, work_d;       // {rem, quo} or product
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               op_div;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mult_next, div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_div = op[OP_DIV_BIT];

`ifdef MULT_DIV_UNSIGNED_EN
    assign op_signed = ~op[OP_UNS_BIT];
`else
    logic unused_op_uns;
    assign op_signed     = 1'b1;
    assign unused_op_uns = op[OP_UNS_BIT];
`endif

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .val_i (a),
        .neg_i (op_signed & a[WIDTH-1]),
        .res_o (a_mag)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .val_i (b),
        .neg_i (op_signed & b[WIDTH-1]),
        .res_o (b_mag)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .val_i (work_q[WIDTH-1:0]),
        .neg_i (neg_lo_q),
        .res_o (quo_fix)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .val_i (work_q[2*WIDTH-1:WIDTH]),
        .neg_i (neg_hi_q),
        .res_o (rem_fix)
    );

    md_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .val_i (work_q),
        .neg_i (neg_lo_q),
        .res_o (prod_fix)
    );

    // single iteration step for both operations; the upper half of the
    // product and the partial remainder share work_q[2W-1:W]
    always_comb begin
        mult_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                  + (work_q[0] ? {1'b0, dvsr_q} : {(WIDTH+1){1'b0}});
        mult_next = {mult_sum, work_q[WIDTH-1:1]};
        div_trial = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, dvsr_q});
        // only used when div_ge, where the true difference fits in WIDTH bits
        div_diff  = div_trial[WIDTH-1:0] - dvsr_q;
        div_next  = {(div_ge ? div_diff : div_trial[WIDTH-1:0]),
                     work_q[WIDTH-2:0], div_ge};
    end

    // next-state and register updates for the controller
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        cnt_d    = cnt_q;
        dvsr_d   = dvsr_q;
        work_d   = work_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_div && (b == '0)) begin
                        dz_d = 1'b1;
                    end else begin
                        is_div_d = op_div;
                        neg_lo_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_d = op_signed & a[WIDTH-1];
                        cnt_d    = '0;
                        dvsr_d   = b_mag;
                        work_d   = {{WIDTH{1'b0}}, a_mag};
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                work_d = is_div_q ? div_next : mult_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo_d    = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            cnt_q    <= '0;
            dvsr_q   <= '0;
            work_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            cnt_q    <= cnt_d;
            dvsr_q   <= dvsr_d;
            work_q   <= work_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit (WIDTH=32): a latency/arithmetic model checked every
// cycle, plus directed operations with hand-computed results.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam int W = 32;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op    = 2'b00;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          busy, done, div_zero;
    logic [W-1:0]  hi, lo;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // arithmetic reference from plain 64-bit integer math
    function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] h, output logic [31:0] l);
        logic   uns;
        longint sx, sy, q, r, p;
`ifdef MULT_DIV_UNSIGNED_EN
        uns = o[1];
`else
        uns = 1'b0;
`endif
        if (uns) begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end
        if (o[0]) begin
            q = sx / sy;
            r = sx % sy;
            h = r[31:0];
            l = q[31:0];
        end else begin
            p = sx * sy;
            h = p[63:32];
            l = p[31:0];
        end
    endfunction

    // cycle model: result appears WIDTH+2 cycles after the start cycle
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic        m_dz   = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                end
            end else if (start) begin
                if (op[0] && b == '0) begin
                    m_dz = 1'b1;
                end else begin
                    model_op(op, a, b, p_hi, p_lo);
                    m_left = W + 1;
                end
            end
        end
    end

    // every-cycle comparison against the model
    initial begin
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            chk("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("div_zero", {31'b0, div_zero}, {31'b0, m_dz});
            chk("busy_done_excl", {31'b0, busy & done}, 32'd0);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n, output int bcnt);
        n    = n0;
        bcnt = busy ? 1 : 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (busy) bcnt++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int n, bc;
        start_op(o, x, y);
        wait_done(1, n, bc);
        chk({name, "_latency"}, n, 32'd34);
        chk({name, "_busy_cycles"}, bc, 32'd33);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    initial begin
        int n, bc, dcnt;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        run_op("mult_7_m3",    OP_MULT, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("mult_m1_m1",   OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_min_m1",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_100_7",    OP_DIV,  32'd100,      32'd7,        32'd2,        32'd14);
        run_op("div_7_m2",     OP_DIV,  32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);

        // divide by zero: one-cycle flag, no operation, HI/LO kept
        start_op(OP_DIV, 32'd5, 32'd0);
        chk("dz_flag", {31'b0, div_zero}, 32'd1);
        chk("dz_busy", {31'b0, busy}, 32'd0);
        chk("dz_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("dz_flag_clear", {31'b0, div_zero}, 32'd0);
        chk("dz_busy2", {31'b0, busy}, 32'd0);
        chk("dz_hi_kept", hi, 32'd1);
        chk("dz_lo_kept", lo, 32'hFFFF_FFFD);

        // start pulsed mid-RUN is ignored
        start_op(OP_MULT, 32'd100, 32'd200);
        n = 1;
        repeat (4) begin @(negedge clk); n++; end
        op = OP_DIV; a = 32'd3; b = 32'd3; start = 1'b1;
        @(negedge clk); n++;
        start = 1'b0;
        wait_done(n, n, bc);
        chk("midstart_latency", n, 32'd34);
        chk("midstart_hi", hi, 32'd0);
        chk("midstart_lo", lo, 32'h0000_4E20);
        // start on the done cycle launches the next op
        op = OP_MULT; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, n, bc);
        chk("backtoback_latency", n, 32'd34);
        chk("backtoback_hi", hi, 32'd0);
        chk("backtoback_lo", lo, 32'd3);

        // reset in cycle 10 of a multiply aborts it
        start_op(OP_MULT, 32'd12345, 32'd678);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 32'd0);

`ifdef MULT_DIV_UNSIGNED_EN
        run_op("divu",  OP_DIVU,  32'hFFFF_FFFF, 32'd2, 32'd1,        32'h7FFF_FFFF);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1,        32'hFFFF_FFFE);
`else
        run_op("divu",  OP_DIVU,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit; successor to the fixed 32-bit mult/div pair that drives the HI/LO path of the multicycle CPU.
- One shared datapath executes signed multiply, signed divide and, optionally, their unsigned variants.
- Uses a start/busy/done handshake and raises a divide-by-zero flag that the control unit routes to its exception handling.
- Results land in internal HI/LO registers, which the CPU reads directly.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are WIDTH bits each; must be ≥ 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 DIV, 10 MULTU, 11 DIVU.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in flight (RUN or FIX).
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_zero  out  1  one-cycle pulse; a divide with b==0 was rejected.
- hi  out  WIDTH  MULT: upper product half. DIV: remainder.
- lo  out  WIDTH  MULT: lower product half. DIV: quotient.

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; counter and working registers cleared. Reset during RUN/FIX aborts the operation, with no done and no HI/LO update.
- FSM states: IDLE, RUN, FIX.
- IDLE + start, at edge E0:
  - If the op is a divide and b==0: div_zero=1 for one cycle; stay in IDLE; hi/lo unchanged.
  - Otherwise: latch op; latch |a| and |b| for signed ops (raw values for unsigned); record result signs; counter=0; go to RUN.
- RUN, edges E1..E_WIDTH: one iteration per edge.
  - Multiply: shift-add on a 2*WIDTH product register.
  - Divide: restoring shift-subtract; quotient bit = 1 when the partial remainder ≥ divisor.
  - At E_WIDTH go to FIX.
- FIX, edge E_(WIDTH+1): apply sign correction; write hi/lo; done=1 for one cycle; go to IDLE.
- Latency: done is high in the cycle after E_(WIDTH+1), i.e. WIDTH+2 cycles after the cycle in which start was sampled.
- busy=1 from the cycle after E0 through the cycle before done. busy and done are never high together.
- start is ignored while busy; a new start is accepted in the same cycle done is high.
- Signed multiply: product negated when sign(a)≠sign(b); result = full 2*WIDTH two's-complement product.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN/−1 wraps: lo=MIN, hi=0, with no exception.
- Operands a, b and op are sampled only at E0; later changes have no effect on the running operation.

Optional Feature:
- Macro: MULT_DIV_UNSIGNED_EN.
- Defined: op[1]=1 selects MULTU/DIVU; operands are treated as unsigned and no sign correction is applied in FIX.
- Undefined: op[1] is ignored, so 10 behaves as MULT and 11 as DIV; the unsigned path is not synthesised.

Decomposition:
- Package mult_div_pkg holds:
  - op encodings: OP_MULT, OP_DIV, OP_MULTU, OP_DIVU;
  - state enum: IDLE, RUN, FIX;
  - WIDTH-independent constants.
- One natural sub-module, md_sign_fix: combinational conditional two's-complement negate, parametrised by WIDTH. It is instantiated for operand absolute values and for the final quotient, remainder and product correction.

Test Plan (WIDTH=32):
- MULT a=7, b=0xFFFFFFFD (−3) -> done at cycle 34 after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high in cycles 1..33.
- DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=5, b=0 -> div_zero=1 in cycle 1 only; busy and done stay 0; hi/lo keep their previous values.
- start pulsed again mid-RUN with different a/b -> ignored; the original result arrives on schedule; start held on the done cycle launches the second operation.
- reset asserted at cycle 10 of a MULT -> cycle 11: busy=0, hi=lo=0, and no done ever appears.
- With MULT_DIV_UNSIGNED_EN: DIVU a=0xFFFFFFFF, b=2 -> lo=0x7FFFFFFF, hi=1; MULTU 0xFFFFFFFF×2 -> hi=1, lo=0xFFFFFFFE. Without the macro, the same DIVU op yields lo=0, hi=0xFFFFFFFF.
